// File: rtl/gray_pkg.sv
// Shared definitions for gray-code blocks: FSM state encoding for the
// decode/step checker and a width-generic gray-to-binary helper.
package gray_pkg;

   // Widest gray word the helper function handles; narrower words are
   // zero-extended, which leaves their low bits decoded correctly.
   localparam int GW = 32;

   // Checker FSM states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_TRACK = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   // b[msb] = g[msb]; each lower bit is the running XOR from the top.
   function automatic logic [GW-1:0] gray2bin_f(input logic [GW-1:0] g);
      logic [GW-1:0] b;
      b = {GW{1'b0}};
      b[GW-1] = g[GW-1];
      for (int i = GW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational gray-to-binary decoder, N bits wide (N <= gray_pkg::GW).
module gray2bin
   import gray_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] gray,
   output logic [N-1:0] bin
);

   assign bin = N'(gray2bin_f(GW'(gray)));

endmodule

// File: rtl/gray_dec_chk.sv
// Gray counter decoder with step checker. Decodes each accepted sample to
// binary one cycle later and classifies the step from the previous sample
// as hold, legal +/-1 (possibly wrapping) or illegal. A three-state FSM
// tracks lock: an illegal step drops to FAULT and RELOCK consecutive legal
// nonzero steps are needed to return to TRACK.
module gray_dec_chk
   import gray_pkg::*;
#(
   parameter int N      = 4,
   parameter int RELOCK = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [N-1:0] gray_in,
   output logic         out_valid,
   output logic [N-1:0] bin_out,
   output logic         step_err,
   output logic         wrap,
   output logic         dir_down,
   output logic         locked,
   output logic [7:0]   err_cnt
);

   localparam logic [N-1:0] MAX_V    = {N{1'b1}};
   localparam logic [N-1:0] ZERO_V   = {N{1'b0}};
   localparam logic [N-1:0] ONE_V    = {{(N-1){1'b0}}, 1'b1};
   localparam logic [3:0]   RELOCK_V = 4'(RELOCK);

   logic [1:0]   state_r;
   logic [1:0]   state_n_s;
   logic [N-1:0] prev_gray_r;
   logic [N-1:0] prev_bin_r;
   logic [3:0]   good_r;
   logic [3:0]   good_n_s;
   logic [3:0]   good_inc_s;
   logic [N-1:0] new_bin_s;
   logic [N-1:0] diff_s;
   logic [5:0]   dist_s;
   logic         hold_s;
   logic         up_s;
   logic         dn_s;
   logic         legal_s;
   logic         illegal_s;
   logic         wrap_s;
   logic         check_en_s;

   logic         out_valid_r;
   logic [N-1:0] bin_r;
   logic         step_err_r;
   logic         wrap_r;
   logic         dir_down_r;
   logic         locked_r;
   logic [7:0]   err_cnt_r;

   gray2bin #(.N(N)) u_dec (
      .gray (gray_in),
      .bin  (new_bin_s)
   );

   assign diff_s     = gray_in ^ prev_gray_r;
   assign good_inc_s = good_r + 4'd1;
   assign check_en_s = in_valid && (state_r != ST_IDLE);

   // Step classification: popcount distance plus N-bit modulo +/-1 compare
   always_comb begin
      dist_s = 6'd0;
      for (int i = 0; i < N; i++) begin
         dist_s = dist_s + {5'd0, diff_s[i]};
      end
      hold_s    = (dist_s == 6'd0);
      up_s      = (new_bin_s == N'(prev_bin_r + ONE_V));
      dn_s      = (new_bin_s == N'(prev_bin_r - ONE_V));
      legal_s   = (dist_s == 6'd1) && (up_s || dn_s);
      illegal_s = !hold_s && !legal_s;
      wrap_s    = legal_s &&
                  (((prev_bin_r == MAX_V) && (new_bin_s == ZERO_V)) ||
                   ((prev_bin_r == ZERO_V) && (new_bin_s == MAX_V)));
   end

   // Lock FSM next state and good-step counter
   always_comb begin
      state_n_s = state_r;
      good_n_s  = good_r;
      if (in_valid) begin
         case (state_r)
            ST_IDLE: begin
               state_n_s = ST_TRACK;
               good_n_s  = 4'd0;
            end
            ST_TRACK: begin
               if (illegal_s) begin
                  state_n_s = ST_FAULT;
                  good_n_s  = 4'd0;
               end else begin
                  state_n_s = ST_TRACK;
                  good_n_s  = good_r;
               end
            end
            ST_FAULT: begin
               if (illegal_s) begin
                  good_n_s = 4'd0;
               end else if (legal_s) begin
                  if (good_inc_s >= RELOCK_V) begin
                     state_n_s = ST_TRACK;
                     good_n_s  = 4'd0;
                  end else begin
                     good_n_s = good_inc_s;
                  end
               end else begin
                  good_n_s = good_r;
               end
            end
            default: begin
               state_n_s = ST_IDLE;
               good_n_s  = 4'd0;
            end
         endcase
      end else begin
         state_n_s = state_r;
         good_n_s  = good_r;
      end
   end

   // FSM state, good counter and sample history
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         good_r      <= 4'd0;
         prev_gray_r <= ZERO_V;
         prev_bin_r  <= ZERO_V;
      end else begin
         state_r <= state_n_s;
         good_r  <= good_n_s;
         if (in_valid) begin
            prev_gray_r <= gray_in;
            prev_bin_r  <= new_bin_s;
         end
      end
   end

   // Registered outputs; pulses only on accepted samples, rest hold otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         bin_r       <= ZERO_V;
         step_err_r  <= 1'b0;
         wrap_r      <= 1'b0;
         dir_down_r  <= 1'b0;
         locked_r    <= 1'b0;
         err_cnt_r   <= 8'd0;
      end else begin
         out_valid_r <= in_valid;
         step_err_r  <= check_en_s && illegal_s;
         wrap_r      <= check_en_s && wrap_s;
         locked_r    <= (state_n_s == ST_TRACK);
         if (in_valid) begin
            bin_r <= new_bin_s;
         end
         if (check_en_s && legal_s) begin
            dir_down_r <= dn_s;
         end
         if (check_en_s && illegal_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
         end
      end
   end

   assign out_valid = out_valid_r;
   assign bin_out   = bin_r;
   assign step_err  = step_err_r;
   assign wrap      = wrap_r;
   assign dir_down  = dir_down_r;
   assign locked    = locked_r;
   assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_gray_dec_chk.sv
// Self-checking bench for gray_dec_chk (N=4, RELOCK=2): directed scenarios,
// error-counter saturation and a randomized stream, all compared against a
// behavioural model built on integer arithmetic.
module tb_gray_dec_chk;

   localparam int N      = 4;
   localparam int RELOCK = 2;
   localparam int MASK   = (1 << N) - 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [N-1:0] gray_in;
   logic         out_valid;
   logic [N-1:0] bin_out;
   logic         step_err;
   logic         wrap;
   logic         dir_down;
   logic         locked;
   logic [7:0]   err_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   bit m_have;
   int m_pb;
   bit m_locked;
   int m_good;
   int m_err;
   bit m_dir;
   int m_bin;
   bit e_ov, e_step, e_wrap;

   gray_dec_chk #(.N(N), .RELOCK(RELOCK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .gray_in   (gray_in),
      .out_valid (out_valid),
      .bin_out   (bin_out),
      .step_err  (step_err),
      .wrap      (wrap),
      .dir_down  (dir_down),
      .locked    (locked),
      .err_cnt   (err_cnt)
   );

   // free-running clock
   always #5 clk = ~clk;

   function automatic int g2b(input int g);
      int b;
      b = g;
      for (int s = 1; s < N; s++) b = b ^ (g >> s);
      return b & MASK;
   endfunction

   function automatic logic [N-1:0] b2g(input int b);
      return N'((b ^ (b >> 1)) & MASK);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update(input bit r, input bit v, input logic [N-1:0] g);
      int nb, d;
      if (r) begin
         m_have = 0; m_pb = 0; m_locked = 0; m_good = 0; m_err = 0;
         m_dir = 0; m_bin = 0; e_ov = 0; e_step = 0; e_wrap = 0;
      end else if (v) begin
         nb = g2b(int'(g));
         e_ov = 1; e_step = 0; e_wrap = 0; m_bin = nb;
         if (!m_have) begin
            m_have = 1; m_locked = 1; m_good = 0;
         end else begin
            d = (nb - m_pb) & MASK;
            if (d == 0) begin
               // hold: nothing changes
            end else if (d == 1 || d == MASK) begin
               m_dir  = (d == MASK);
               e_wrap = (m_pb == MASK && nb == 0) || (m_pb == 0 && nb == MASK);
               if (!m_locked) begin
                  m_good++;
                  if (m_good >= RELOCK) begin
                     m_locked = 1; m_good = 0;
                  end
               end
            end else begin
               e_step = 1;
               if (m_err < 255) m_err++;
               m_locked = 0; m_good = 0;
            end
         end
         m_pb = nb;
      end else begin
         e_ov = 0; e_step = 0; e_wrap = 0;
      end
   endtask

   task automatic step(input bit r, input bit v, input logic [N-1:0] g);
      rst = r; in_valid = v; gray_in = g;
      @(posedge clk);
      #1;
      model_update(r, v, g);
      check("out_valid", 32'(out_valid), 32'(e_ov));
      check("bin_out",   32'(bin_out),   32'(m_bin));
      check("step_err",  32'(step_err),  32'(e_step));
      check("wrap",      32'(wrap),      32'(e_wrap));
      check("dir_down",  32'(dir_down),  32'(m_dir));
      check("locked",    32'(locked),    32'(m_locked));
      check("err_cnt",   32'(err_cnt),   32'(m_err));
   endtask

   initial begin
      int wraps;
      int r, k, b;
      rst = 1'b1; in_valid = 1'b0; gray_in = '0;

      // reset state
      step(1'b1, 1'b0, 4'h0);
      step(1'b0, 1'b0, 4'h0);
      check("rst_bin", 32'(bin_out), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);

      // full count 0..15 then 0
      wraps = 0;
      for (int i = 0; i <= 16; i++) begin
         step(1'b0, 1'b1, b2g(i & MASK));
         check("seq_bin", 32'(bin_out), 32'(i & MASK));
         check("seq_locked", 32'(locked), 32'd1);
         if (wrap) wraps++;
      end
      check("seq_wraps", 32'(wraps), 32'd1);
      check("seq_err", 32'(err_cnt), 32'd0);

      // illegal steps, fault and relock
      step(1'b1, 1'b0, 4'h0);
      step(1'b0, 1'b1, 4'h7);
      step(1'b0, 1'b1, 4'h4);
      check("r32_step", 32'(step_err), 32'd1);
      check("r32_err", 32'(err_cnt), 32'd1);
      check("r32_locked", 32'(locked), 32'd0);
      step(1'b0, 1'b1, 4'h5);
      check("r33_locked", 32'(locked), 32'd0);
      step(1'b0, 1'b1, 4'hF);
      check("r33_step", 32'(step_err), 32'd1);
      check("r33_err", 32'(err_cnt), 32'd2);
      step(1'b0, 1'b1, 4'hE);
      check("r34_locked_e", 32'(locked), 32'd0);
      step(1'b0, 1'b1, 4'hA);
      check("r34_locked_a", 32'(locked), 32'd1);
      step(1'b0, 1'b1, 4'hB);
      check("r34_bin", 32'(bin_out), 32'd13);
      step(1'b0, 1'b0, 4'h3);

      // down-wrap 0 -> 15
      step(1'b1, 1'b0, 4'h0);
      step(1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 4'h8);
      check("r35_wrap", 32'(wrap), 32'd1);
      check("r35_dir", 32'(dir_down), 32'd1);
      check("r35_step", 32'(step_err), 32'd0);

      // reset wins over in_valid; history discarded
      step(1'b0, 1'b1, 4'h9);
      step(1'b1, 1'b1, 4'h5);
      check("r36_ov_rst", 32'(out_valid), 32'd0);
      step(1'b0, 1'b1, 4'hC);
      check("r36_bin", 32'(bin_out), 32'd8);
      check("r36_err", 32'(err_cnt), 32'd0);
      check("r36_step", 32'(step_err), 32'd0);

      // err_cnt saturation
      step(1'b1, 1'b0, 4'h0);
      step(1'b0, 1'b1, 4'h0);
      for (int i = 0; i < 270; i++) begin
         step(1'b0, 1'b1, (i % 2 == 0) ? 4'h3 : 4'h0);
      end
      check("sat_err", 32'(err_cnt), 32'd255);

      // randomized stream
      step(1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            step(1'b1, 1'($urandom_range(0, 1)), N'($urandom));
         end else if (r < 15) begin
            step(1'b0, 1'b0, N'($urandom));
         end else if (r < 75) begin
            k = int'($urandom_range(0, 1));
            b = (k == 1) ? (m_pb + 1) & MASK : (m_pb + MASK) & MASK;
            step(1'b0, 1'b1, b2g(b));
         end else if (r < 85) begin
            step(1'b0, 1'b1, b2g(m_pb));
         end else begin
            step(1'b0, 1'b1, N'($urandom));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
